// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 holding BadVAddr, Count, Compare, Status, Cause and EPC,
// with precise exception/ERET commit, masked interrupt request and a Count prescaler.
module cp0_unit #(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] INT_VECTOR = 32'hBFC00380
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid,
    input  logic [4:0]            exccode_i,
    input  logic                  eret_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_i,
    input  logic [31:0]           badvaddr_i,
    output logic                  int_req,
    output logic                  flush,
    output logic                  flush_im,
    output logic [31:0]           excaddr,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic                  timer_int_o
);
    logic [31:0] badvaddr, count, compare, epc, presc;
    logic [7:0]  im;
    logic        exl, ie, bd, ti, mtc;
    logic [5:0]  ip_hw, hw_next;
    logic [1:0]  ip_sw;
    logic [4:0]  exccode;

    assign mtc      = we & ~exc_valid & ~eret_i;
    assign status_o = {3'b0, 1'b1, 12'b0, im, 6'b0, exl, ie};
    assign cause_o  = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};
    assign int_req  = ie & ~exl & |(im & {ip_hw, ip_sw});
    assign flush    = ~cpu_rst & (exc_valid | eret_i);

    // ERET redirect forwards an EPC write that the ERET itself suppresses
    assign excaddr = cpu_rst ? 32'hBFC00000 :
                     exc_valid ? (exccode_i == 5'd0 ? INT_VECTOR : EXC_VECTOR) :
                     eret_i ? ((we && waddr == 5'd14) ? wdata : epc) : 32'h0;

    assign rdata = (cpu_rst || !re) ? 32'h0 :
                   raddr == 5'd8  ? badvaddr :
                   raddr == 5'd9  ? count :
                   raddr == 5'd11 ? compare :
                   raddr == 5'd12 ? status_o :
                   raddr == 5'd13 ? cause_o :
                   raddr == 5'd14 ? epc : 32'h0;

    always_comb begin
        hw_next = '0;
        hw_next[NUM_HW_INT-1:0] = int_i;
        hw_next[5] = hw_next[5] | timer_int_o;
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            badvaddr    <= '0;
            count       <= '0;
            compare     <= '0;
            epc         <= '0;
            presc       <= '0;
            im          <= '0;
            exl         <= 1'b0;
            ie          <= 1'b0;
            bd          <= 1'b0;
            ti          <= 1'b0;
            ip_hw       <= '0;
            ip_sw       <= '0;
            exccode     <= '0;
            timer_int_o <= 1'b0;
            flush_im    <= 1'b0;
        end else begin
            ip_hw    <= hw_next;
            ti       <= timer_int_o;
            flush_im <= flush;
            if (mtc && waddr == 5'd9) begin
                count <= wdata;
                presc <= '0;
            end else if (presc == 32'(COUNT_DIV - 1)) begin
                presc <= '0;
                count <= count + 32'd1;
            end else begin
                presc <= presc + 32'd1;
            end
            if (mtc && waddr == 5'd11)
                timer_int_o <= 1'b0;
            else if (count == compare)
                timer_int_o <= 1'b1;
            if (exc_valid) begin
                if (!exl) begin
                    epc <= in_delay_i ? pc_i - 32'd4 : pc_i;
                    bd  <= in_delay_i;
                end
                exl     <= 1'b1;
                exccode <= exccode_i;
                if (exccode_i == 5'd4 || exccode_i == 5'd5)
                    badvaddr <= badvaddr_i;
            end else if (eret_i) begin
                exl <= 1'b0;
            end else if (we) begin
                case (waddr)
                    5'd8:    badvaddr <= wdata;
                    5'd11:   compare <= wdata;
                    5'd12:   {im, exl, ie} <= {wdata[15:8], wdata[1], wdata[0]};
                    5'd13:   ip_sw <= wdata[9:8];
                    5'd14:   epc <= wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the CP0 register file.
module tb_cp0_unit;
    localparam int DIV = 2;
    localparam logic [31:0] EXC_V = 32'hBFC00380;
    localparam logic [31:0] INT_V = 32'hBFC00380;

    logic        clk = 1'b0, rst = 1'b1;
    logic        we, re, exc_valid, eret, in_delay;
    logic [4:0]  waddr, raddr, exccode;
    logic [31:0] wdata, pc, badv;
    logic [5:0]  int_i;
    logic [31:0] rdata, excaddr, status_o, cause_o;
    logic        int_req, flush, flush_im, timer_int;

    int errors = 0, checks = 0;

    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_cmp;
    int          m_ticks;
    logic        m_timer, m_fim;

    always #10 clk = ~clk;

    cp0_unit #(.NUM_HW_INT(6), .COUNT_DIV(DIV), .EXC_VECTOR(EXC_V), .INT_VECTOR(INT_V)) dut (
        .cpu_clk_50M(clk), .cpu_rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .int_i(int_i), .exc_valid(exc_valid),
        .exccode_i(exccode), .eret_i(eret), .pc_i(pc), .in_delay_i(in_delay),
        .badvaddr_i(badv), .int_req(int_req), .flush(flush), .flush_im(flush_im),
        .excaddr(excaddr), .status_o(status_o), .cause_o(cause_o), .timer_int_o(timer_int)
    );

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0; int_i = 0;
        exc_valid = 0; exccode = 0; eret = 0; pc = 0; in_delay = 0; badv = 0;
    endtask

    task automatic model_reset();
        m_status = 32'h10000000; m_cause = 0; m_epc = 0; m_bad = 0;
        m_count = 0; m_cmp = 0; m_ticks = 0; m_timer = 0; m_fim = 0;
    endtask

    function automatic logic [31:0] exp_rdata();
        if (!re) return 32'h0;
        case (raddr)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_cmp;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_excaddr();
        if (exc_valid) return exccode == 0 ? INT_V : EXC_V;
        if (eret) return (we && waddr == 14) ? wdata : m_epc;
        return 32'h0;
    endfunction

    function automatic logic exp_int_req();
        return m_status[0] && !m_status[1] && (|(m_status[15:8] & m_cause[15:8]));
    endfunction

    // advance the model by one clock from the currently driven inputs, then wait for the edge
    task automatic tick();
        logic [31:0] n_status, n_cause, n_epc, n_bad, n_count, n_cmp;
        logic [5:0]  ip;
        logic        n_timer, mtc;
        int          n_ticks;
        mtc = we && !exc_valid && !eret;
        n_status = m_status; n_epc = m_epc; n_bad = m_bad; n_cmp = m_cmp;
        ip = {int_i[5] | m_timer, int_i[4:0]};
        n_cause = (m_cause & ~32'h4000FC00) | (32'(ip) << 10) | (32'(m_timer) << 30);
        if (mtc && waddr == 9) begin
            n_count = wdata; n_ticks = 0;
        end else begin
            n_count = m_count; n_ticks = m_ticks + 1;
            if (n_ticks == DIV) begin n_ticks = 0; n_count = m_count + 1; end
        end
        n_timer = (mtc && waddr == 11) ? 1'b0 : (m_count == m_cmp) ? 1'b1 : m_timer;
        if (exc_valid) begin
            if (!m_status[1]) begin
                n_epc = in_delay ? pc - 4 : pc;
                n_cause[31] = in_delay;
            end
            n_status[1] = 1'b1;
            n_cause[6:2] = exccode;
            if (exccode == 4 || exccode == 5) n_bad = badv;
        end else if (eret) begin
            n_status[1] = 1'b0;
        end
        if (mtc) begin
            if (waddr == 8) n_bad = wdata;
            if (waddr == 11) n_cmp = wdata;
            if (waddr == 12) n_status = 32'h10000000 | (wdata & 32'h0000FF03);
            if (waddr == 13) n_cause = (n_cause & ~32'h300) | (wdata & 32'h300);
            if (waddr == 14) n_epc = wdata;
        end
        @(posedge clk); #1;
        m_fim = exc_valid || eret;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
        m_count = n_count; m_cmp = n_cmp; m_ticks = n_ticks; m_timer = n_timer;
    endtask

    task automatic test_reset();
        int addrs[6] = '{8, 9, 11, 12, 13, 14};
        logic [31:0] want[6] = '{0, 0, 0, 32'h10000000, 0, 0};
        idle(); rst = 1;
        repeat (2) @(posedge clk);
        #1; rst = 0; model_reset();
        for (int i = 0; i < 6; i++) begin
            re = 1; raddr = 5'(addrs[i]); #1;
            checks++;
            if (rdata !== want[i]) begin errors++; $display("FAIL reset_read[%0d]: got %h want %h", addrs[i], rdata, want[i]); end
        end
        checks++;
        if (flush_im !== 1'b0 || timer_int !== 1'b0) begin errors++; $display("FAIL reset_flags: flush_im=%b timer=%b want 0 0", flush_im, timer_int); end
        re = 0;
        repeat (10) tick();
        re = 1; raddr = 9; #1;
        checks++;
        if (rdata !== 32'd5) begin errors++; $display("FAIL count_after_10: got %h want %h", rdata, 32'd5); end
        re = 0;
    endtask

    task automatic test_timer();
        idle(); we = 1; waddr = 11; wdata = 3; tick();
        waddr = 9; wdata = 0; tick();
        idle();
        for (int i = 0; i < 20 && !timer_int; i++) begin
            tick();
            checks++;
            if (timer_int !== m_timer) begin errors++; $display("FAIL timer_track: got %b want %b", timer_int, m_timer); end
        end
        checks++;
        if (timer_int !== 1'b1) begin errors++; $display("FAIL timer_timeout: got %b want 1", timer_int); end
        re = 1; raddr = 9; #1;
        checks++;
        if (rdata !== 32'd3) begin errors++; $display("FAIL timer_count: got %h want %h", rdata, 32'd3); end
        re = 0; tick();
        checks++;
        if (cause_o[30] !== 1'b1 || cause_o[15] !== 1'b1) begin errors++; $display("FAIL timer_cause: got %h want bits 30,15 set", cause_o); end
        we = 1; waddr = 11; wdata = 0; tick(); idle();
        checks++;
        if (timer_int !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b want 0", timer_int); end
    endtask

    task automatic test_int();
        idle(); we = 1; waddr = 12; wdata = 32'h1000FF01; int_i = 6'b1;
        #1;
        checks++;
        if (int_req !== exp_int_req()) begin errors++; $display("FAIL int_pre: got %b want %b", int_req, exp_int_req()); end
        tick(); we = 0;
        checks++;
        if (int_req !== exp_int_req()) begin errors++; $display("FAIL int_mid: got %b want %b", int_req, exp_int_req()); end
        tick();
        checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL int_raise: got %b want 1", int_req); end
        we = 1; waddr = 12; wdata = 32'h1000FF03; tick();
        checks++;
        if (int_req !== 1'b0) begin errors++; $display("FAIL int_exl_mask: got %b want 0", int_req); end
        wdata = 32'h1000FF00; int_i = 0; tick(); idle();
    endtask

    task automatic test_exc();
        idle(); exc_valid = 1; exccode = 4; pc = 32'h80000104; in_delay = 1; badv = 32'h3;
        #1;
        checks++;
        if (flush !== 1'b1 || excaddr !== 32'hBFC00380) begin errors++; $display("FAIL exc_redirect: flush=%b excaddr=%h want 1 bfc00380", flush, excaddr); end
        tick(); idle();
        re = 1; raddr = 14; #1;
        checks++;
        if (rdata !== 32'h80000100) begin errors++; $display("FAIL exc_epc: got %h want %h", rdata, 32'h80000100); end
        raddr = 8; #1;
        checks++;
        if (rdata !== 32'h3) begin errors++; $display("FAIL exc_badvaddr: got %h want %h", rdata, 32'h3); end
        checks++;
        if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4 || status_o[1] !== 1'b1) begin errors++; $display("FAIL exc_state: cause=%h status=%h want BD=1 code=4 EXL=1", cause_o, status_o); end
        checks++;
        if (flush_im !== 1'b1) begin errors++; $display("FAIL exc_flush_im: got %b want 1", flush_im); end
        re = 0; tick();
        checks++;
        if (flush_im !== 1'b0) begin errors++; $display("FAIL exc_flush_im_drop: got %b want 0", flush_im); end
    endtask

    task automatic test_exc_nested();
        idle(); exc_valid = 1; exccode = 12; pc = 32'h80000200; tick(); idle();
        re = 1; raddr = 14; #1;
        checks++;
        if (rdata !== 32'h80000100 || cause_o[6:2] !== 5'd12) begin errors++; $display("FAIL nested_exc: epc=%h code=%0d want 80000100 12", rdata, cause_o[6:2]); end
        re = 0;
    endtask

    task automatic test_eret_bypass();
        idle(); eret = 1; we = 1; waddr = 14; wdata = 32'h80001000;
        #1;
        checks++;
        if (excaddr !== 32'h80001000 || flush !== 1'b1) begin errors++; $display("FAIL eret_bypass: excaddr=%h flush=%b want 80001000 1", excaddr, flush); end
        tick(); idle();
        re = 1; raddr = 14; #1;
        checks++;
        if (rdata !== 32'h80000100 || status_o[1] !== 1'b0) begin errors++; $display("FAIL eret_state: epc=%h exl=%b want 80000100 0", rdata, status_o[1]); end
        re = 0;
    endtask

    task automatic test_exc_drops_mtc();
        idle(); exc_valid = 1; exccode = 8; pc = 32'h80000300; we = 1; waddr = 12; wdata = 32'h1000FF01;
        tick(); idle();
        checks++;
        if (status_o !== m_status || status_o[0] !== 1'b0 || status_o[1] !== 1'b1) begin errors++; $display("FAIL exc_drops_mtc: got %h want %h", status_o, m_status); end
    endtask

    task automatic test_random();
        int wsel[6] = '{9, 11, 12, 13, 14, 3};
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 1) == 1);
            waddr = 5'(wsel[$urandom_range(0, 5)]);
            wdata = $urandom;
            if (waddr == 11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(0, 4);
            re = ($urandom_range(0, 3) != 0);
            raddr = 5'($urandom_range(0, 31));
            int_i = 6'($urandom);
            exc_valid = ($urandom_range(0, 7) == 0);
            exccode = 5'($urandom_range(0, 13));
            eret = ($urandom_range(0, 7) == 0);
            pc = $urandom & 32'hFFFFFFFC;
            in_delay = ($urandom_range(0, 1) == 1);
            badv = $urandom;
            #1;
            checks++;
            if (rdata !== exp_rdata()) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata, exp_rdata()); end
            checks++;
            if (flush !== (exc_valid | eret) || excaddr !== exp_excaddr()) begin errors++; $display("FAIL rnd_redirect[%0d]: flush=%b excaddr=%h want %b %h", n, flush, excaddr, exc_valid | eret, exp_excaddr()); end
            checks++;
            if (int_req !== exp_int_req()) begin errors++; $display("FAIL rnd_int_req[%0d]: got %b want %b", n, int_req, exp_int_req()); end
            checks++;
            if (status_o !== m_status || cause_o !== m_cause) begin errors++; $display("FAIL rnd_regs[%0d]: status=%h cause=%h want %h %h", n, status_o, cause_o, m_status, m_cause); end
            checks++;
            if (timer_int !== m_timer || flush_im !== m_fim) begin errors++; $display("FAIL rnd_flags[%0d]: timer=%b flush_im=%b want %b %b", n, timer_int, flush_im, m_timer, m_fim); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle(); int_i = 6'h3F; we = 1; waddr = 12; wdata = 32'h1000FF03; tick();
        idle(); int_i = 6'h3F; exc_valid = 1; exccode = 4; pc = 32'h80000010; badv = 32'h55; tick();
        #5; rst = 1; re = 1; raddr = 12;
        #1;
        checks++;
        if (status_o !== 32'h10000000 || cause_o !== 32'h0) begin errors++; $display("FAIL async_regs: status=%h cause=%h want 10000000 0", status_o, cause_o); end
        checks++;
        if (timer_int !== 1'b0 || flush_im !== 1'b0 || int_req !== 1'b0) begin errors++; $display("FAIL async_flags: timer=%b flush_im=%b int_req=%b want 0 0 0", timer_int, flush_im, int_req); end
        checks++;
        if (flush !== 1'b0 || excaddr !== 32'hBFC00000 || rdata !== 32'h0) begin errors++; $display("FAIL async_comb: flush=%b excaddr=%h rdata=%h want 0 bfc00000 0", flush, excaddr, rdata); end
        #1; idle(); rst = 0; model_reset(); re = 1; raddr = 8;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL async_badvaddr: got %h want 0", rdata); end
        raddr = 14; #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL async_epc: got %h want 0", rdata); end
        re = 0;
    endtask

    initial begin
        idle(); model_reset();
        test_reset();
        test_timer();
        test_int();
        test_exc();
        test_exc_nested();
        test_eret_bypass();
        test_exc_drops_mtc();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Parametrised next-generation coprocessor-0 block for the MIPS pipeline. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and records precise exceptions and ERET. It adds masked interrupt-request generation, a configurable Count prescaler and write masks on Status/Cause. It sits beside the MEM stage, drives pipeline flush and redirect, and supplies the interrupt request sampled by the exception-detect logic.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[10+i]
COUNT_DIV, 2, core cycles per Count increment (>=1)
EXC_VECTOR, 32'hBFC00380, redirect address for every non-interrupt exception
INT_VECTOR, 32'hBFC00380, redirect address for exccode 0 (Int)

Ports:
cpu_clk_50M  in  1  core clock
cpu_rst  in  1  asynchronous reset, active-high
we  in  1  MTC0 write enable
waddr  in  5  MTC0 register number
wdata  in  32  MTC0 data
re  in  1  MFC0 read enable
raddr  in  5  MFC0 register number
rdata  out  32  MFC0 read data (combinational)
int_i  in  NUM_HW_INT  hardware interrupt lines (level, synchronous to the clock)
exc_valid  in  1  exception committed this cycle
exccode_i  in  5  MIPS ExcCode, valid with exc_valid
eret_i  in  1  ERET committed this cycle
pc_i  in  32  PC of the committing instruction
in_delay_i  in  1  committing instruction is in a delay slot
badvaddr_i  in  32  faulting address for AdEL/AdES
int_req  out  1  pending enabled interrupt
flush  out  1  pipeline flush (combinational)
flush_im  out  1  flush delayed by one cycle, for the instruction-memory return path
excaddr  out  32  redirect PC
status_o  out  32  Status
cause_o  out  32  Cause
timer_int_o  out  1  timer interrupt latch

Behaviour:
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. All other addresses read 0, and writes to them are ignored.
- Reset (asynchronous) values:
  - Status = 32'h10000000.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Prescaler = 0.
  - timer_int_o = 0, flush_im = 0.
  - During reset: flush = 0, excaddr = 32'hBFC00000, rdata = 0.
- Write masks:
  - Status: bit 28 is fixed at 1. Only IM[15:8], EXL[1] and IE[0] are writable. All other bits read 0.
  - Cause: only IP[9:8] (software interrupts) are writable.
- Cause hardware bits, updated every cycle (registered):
  - IP[10+i] <= int_i[i]. IP bits above NUM_HW_INT are 0.
  - IP[15] additionally ORs in timer_int_o.
  - TI[30] <= timer_int_o.
- int_req = Status.IE & ~Status.EXL & |(Status.IM[15:8] & Cause.IP[15:8]). It is combinational from registered state.
- Count prescaler:
  - Counts 0..COUNT_DIV-1. Count increments on the wrap cycle and wraps from 32'hFFFFFFFF to 0.
  - With COUNT_DIV=1, Count increments every cycle.
  - An MTC0 to Count loads wdata and clears the prescaler. The write wins over the increment in the same cycle.
- Timer:
  - timer_int_o sets on the clock edge where registered Count == Compare. It is sticky.
  - It is cleared only by an MTC0 to Compare. A clear in the same cycle as a match wins.
- Commit priority per cycle: exc_valid > eret_i > MTC0. MTC0 is suppressed when exc_valid or eret_i is high.
- Exception (exc_valid=1):
  - If Status.EXL was 0: EPC <= in_delay_i ? pc_i-4 : pc_i, and Cause.BD[31] <= in_delay_i.
  - If Status.EXL was 1: EPC and BD are unchanged.
  - Always: EXL <= 1 and Cause.ExcCode[6:2] <= exccode_i.
  - For exccode 4 or 5, BadVAddr <= badvaddr_i.
- ERET: EXL <= 0.
- flush = exc_valid | eret_i. flush_im <= flush on each clock edge.
- excaddr:
  - exc_valid with exccode 0: INT_VECTOR.
  - Any other exception: EXC_VECTOR.
  - eret_i: EPC, except when a same-cycle MTC0 to EPC is present; then wdata is bypassed.
  - Otherwise: 0.
- rdata: re=0 gives 0. Otherwise the current register value, with no same-cycle write bypass.

Test Plan:
- Reset, then read all six registers -> Status 32'h10000000, all others 0. Count reaches 5 after 10 cycles with COUNT_DIV=2.
- Write Compare=3 and Count=0 -> timer_int_o=1 on the edge where Count hits 3, Cause[30]=1 and Cause[15]=1. Writing Compare=0 clears timer_int_o next cycle.
- Status=32'h1000FF01 and int_i[0]=1 -> int_req=1 two cycles later. Setting EXL=1 drops int_req.
- exc_valid with exccode 4, pc_i=32'h80000104, in_delay_i=1, badvaddr_i=32'h3 -> EPC=32'h80000100, BD=1, BadVAddr=3, EXL=1, flush=1, excaddr=32'hBFC00380, flush_im=1 next cycle.
- Second exception while EXL=1 -> EPC unchanged, ExcCode updated.
- eret_i with same-cycle MTC0 EPC=32'h80001000 -> excaddr=32'h80001000, EPC not written, EXL=0.
- exc_valid and MTC0 Status in the same cycle -> write dropped.
- cpu_rst asserted mid-run -> all state reverts to reset values immediately, without waiting for a clock edge.
